// File: rtl/vec_exec_pipe_if.sv
// Handshake/data bundle for vec_exec_pipe: request side (valid_in/ready_out) and
// result side (valid_out/ready_in), plus flush.
interface vec_exec_pipe_if #(
  parameter int LANES = 9,
  parameter int EW    = 9,
  parameter int RW    = 32,
  parameter int TAGW  = 4
);
  logic                       valid_in;
  logic                       ready_out;
  logic [1:0]                 op;
  logic [LANES-1:0]           lane_en;
  logic [LANES-1:0][EW-1:0]   a;
  logic [LANES-1:0][EW-1:0]   b;
  logic [TAGW-1:0]            tag_in;
  logic                       flush;
  logic                       valid_out;
  logic                       ready_in;
  logic [LANES-1:0][EW-1:0]   vres;
  logic [RW-1:0]              sres;
  logic [TAGW-1:0]            tag_out;
  logic                       is_dot_out;

  modport slave (
    input  valid_in, op, lane_en, a, b, tag_in, flush, ready_in,
    output ready_out, valid_out, vres, sres, tag_out, is_dot_out
  );

  modport master (
    output valid_in, op, lane_en, a, b, tag_in, flush, ready_in,
    input  ready_out, valid_out, vres, sres, tag_out, is_dot_out
  );
endinterface

// File: rtl/vec_exec_pipe.sv
// vec_exec_pipe: 2-stage lane-wise VADD/VSUB/VMUL and VDOT unit with valid/ready, tag, mask, flush.
// Define VEC_EXEC_SAT_EN to saturate lane results instead of wrapping.

module vec_exec_lane #(
  parameter int EW = 9
) (
  input  logic [1:0]           op,
  input  logic                 en,
  input  logic signed [EW-1:0] a,
  input  logic signed [EW-1:0] b,
  output logic [EW-1:0]        elem,
  output logic [2*EW-1:0]      prod
);
  logic signed [2*EW-1:0] p_full;

  assign p_full = a * b;
  assign prod   = en ? p_full : '0;

`ifdef VEC_EXEC_SAT_EN
  localparam logic signed [2*EW-1:0] SMAX = {{(EW+1){1'b0}}, {(EW-1){1'b1}}};
  localparam logic signed [2*EW-1:0] SMIN = ~SMAX;
  logic signed [2*EW-1:0] wide;

  always_comb begin
    case (op)
      2'b00:   wide = a + b;
      2'b01:   wide = a - b;
      2'b10:   wide = p_full;
      default: wide = a;
    endcase
    if (!en)               elem = a;
    else if (wide > SMAX)  elem = SMAX[EW-1:0];
    else if (wide < SMIN)  elem = SMIN[EW-1:0];
    else                   elem = wide[EW-1:0];
  end
`else
  always_comb begin
    case (op)
      2'b00:   elem = a + b;
      2'b01:   elem = a - b;
      2'b10:   elem = p_full[EW-1:0];
      default: elem = a;
    endcase
    if (!en) elem = a;
  end
`endif
endmodule

module vec_exec_pipe #(
  parameter int LANES = 9,
  parameter int EW    = 9,
  parameter int RW    = 32,
  parameter int TAGW  = 4
) (
  input  logic          clk,
  input  logic          reset,
  vec_exec_pipe_if.slave bus
);
  localparam int STAGES = 2;

  typedef struct packed {
    logic                         dot;
    logic [TAGW-1:0]              tag;
    logic [LANES-1:0][EW-1:0]     elem;
    logic [LANES-1:0][2*EW-1:0]   prod;
  } s1_t;

  logic [STAGES:1]             vld_pipe;
  s1_t                         s1;
  logic [LANES-1:0][EW-1:0]    lane_elem;
  logic [LANES-1:0][2*EW-1:0]  lane_prod;
  logic [RW-1:0]               dot_sum;
  logic                        s2_load, s1_load, accept;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    vec_exec_lane #(.EW(EW)) u_lane (
      .op   (bus.op),
      .en   (bus.lane_en[i]),
      .a    (bus.a[i]),
      .b    (bus.b[i]),
      .elem (lane_elem[i]),
      .prod (lane_prod[i])
    );
  end

  // Stall only propagates backwards through full stages.
  assign s2_load       = !vld_pipe[2] || bus.ready_in;
  assign s1_load       = !vld_pipe[1] || s2_load;
  assign accept        = bus.valid_in && s1_load;
  assign bus.ready_out = s1_load;
  assign bus.valid_out = vld_pipe[2];

  always_comb begin
    dot_sum = '0;
    for (int i = 0; i < LANES; i++)
      dot_sum = dot_sum + {{(RW-2*EW){s1.prod[i][2*EW-1]}}, s1.prod[i]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe       <= '0;
      s1             <= '0;
      bus.vres       <= '0;
      bus.sres       <= '0;
      bus.tag_out    <= '0;
      bus.is_dot_out <= 1'b0;
    end else begin
      if (bus.flush) begin
        vld_pipe <= '0;
      end else begin
        if (s2_load) vld_pipe[2] <= vld_pipe[1];
        if (s1_load) vld_pipe[1] <= accept;
      end
      if (accept) begin
        s1.dot  <= (bus.op == 2'b11);
        s1.tag  <= bus.tag_in;
        s1.elem <= lane_elem;
        s1.prod <= lane_prod;
      end
      // Output registers only change on a real advance, so they hold under backpressure.
      if (s2_load && vld_pipe[1]) begin
        bus.tag_out    <= s1.tag;
        bus.is_dot_out <= s1.dot;
        bus.vres       <= s1.dot ? '0 : s1.elem;
        bus.sres       <= s1.dot ? dot_sum : '0;
      end
    end
  end
endmodule
